// File: rtl/vending_pkg.sv
// Shared types and defaults for the meal vending controller.
package vending_pkg;

    // Default bus width for cash, price, item and change.
    localparam int DATA_W_DEF    = 8;
    // Default code presented on dispensed_item after a successful vend.
    localparam int ITEM_CODE_DEF = 1;

    // Transaction FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EVAL   = 3'd1,
        VEND   = 3'd2,
        REFUND = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Why a transaction ended in a refund.
    // This value is only meaningful when the price check reports not ok.
    typedef enum logic [1:0] {
        RSN_CANCEL   = 2'd0,
        RSN_NO_FUNDS = 2'd1,
        RSN_NO_STOCK = 2'd2
    } refund_reason_t;

endpackage

// File: rtl/vending_price_check.sv
// Combinational affordability check: decides vend vs refund and computes change.
module vending_price_check
    import vending_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] cash,
    input  logic [DATA_W-1:0] price,
    input  logic              avail,
    output logic              ok,
    output logic [DATA_W-1:0] change,
    output logic [1:0]        reason
);

    refund_reason_t reason_t_val;

    // Stock is checked before funds, so an out-of-stock item is reported as such
    // even when the credit is also short. Change is zero whenever the vend is refused,
    // which keeps the subtraction from ever wrapping.
    always_comb begin
        ok           = 1'b0;
        change       = '0;
        reason_t_val = RSN_CANCEL;
        if (!avail) begin
            reason_t_val = RSN_NO_STOCK;
        end else if (cash < price) begin
            reason_t_val = RSN_NO_FUNDS;
        end else begin
            ok     = 1'b1;
            change = cash - price;
        end
    end

    assign reason = reason_t_val;

endmodule

// File: rtl/vending_machine_meal.sv
// Single-item meal vending controller: evaluates credit against price and stock,
// then either vends with change or refunds the credit. The result sticks until reset.
//
// Request semantics: select_item and cancel are levels sampled on every rising edge
// while in IDLE. The first edge that sees either one accepts the request (cancel wins
// if both are high) and captures insert_cash/item_price/item_available; nothing is
// sampled again until reset, so a held level never retriggers and later input changes
// cannot disturb the transaction in flight.
module vending_machine_meal
    import vending_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] ITEM_CODE = DATA_W'(ITEM_CODE_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] insert_cash,
    input  logic [DATA_W-1:0] item_price,
    input  logic              item_available,
    input  logic              select_item,
    input  logic              cancel,
    output logic [DATA_W-1:0] dispensed_item,
    output logic [DATA_W-1:0] dispensed_change,
    output logic              error,
    output logic [2:0]        dbg_state,
    output logic [1:0]        dbg_reason
);

    state_t            state;
    logic [DATA_W-1:0] cash_q;
    logic [DATA_W-1:0] price_q;
    logic              avail_q;
    logic              refund_err_q;
    refund_reason_t    reason_q;

    logic              chk_ok;
    logic [DATA_W-1:0] chk_change;
    logic [1:0]        chk_reason;

    // The check always looks at the captured values, never the live inputs.
    vending_price_check #(
        .DATA_W (DATA_W)
    ) u_price_check (
        .cash   (cash_q),
        .price  (price_q),
        .avail  (avail_q),
        .ok     (chk_ok),
        .change (chk_change),
        .reason (chk_reason)
    );

    // Transaction FSM with capture registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cash_q           <= '0;
            price_q          <= '0;
            avail_q          <= 1'b0;
            refund_err_q     <= 1'b0;
            reason_q         <= RSN_CANCEL;
            dispensed_item   <= '0;
            dispensed_change <= '0;
            error            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cancel) begin
                        cash_q       <= insert_cash;
                        refund_err_q <= 1'b0;
                        reason_q     <= RSN_CANCEL;
                        state        <= REFUND;
                    end else if (select_item) begin
                        cash_q  <= insert_cash;
                        price_q <= item_price;
                        avail_q <= item_available;
                        state   <= EVAL;
                    end
                end
                EVAL: begin
                    if (chk_ok) begin
                        state <= VEND;
                    end else begin
                        refund_err_q <= 1'b1;
                        reason_q     <= refund_reason_t'(chk_reason);
                        state        <= REFUND;
                    end
                end
                VEND: begin
                    dispensed_item   <= ITEM_CODE;
                    dispensed_change <= chk_change;
                    error            <= 1'b0;
                    state            <= DONE;
                end
                REFUND: begin
                    dispensed_item   <= '0;
                    dispensed_change <= cash_q;
                    error            <= refund_err_q;
                    state            <= DONE;
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state  = state;
    assign dbg_reason = reason_q;

endmodule

// File: tb/tb_vending_machine_meal.sv
// Directed bench for vending_machine_meal with hand-computed expectations.
module tb_vending_machine_meal;
    import vending_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] insert_cash;
    logic [7:0] item_price;
    logic       item_available;
    logic       select_item;
    logic       cancel;
    logic [7:0] dispensed_item;
    logic [7:0] dispensed_change;
    logic       error;
    logic [2:0] dbg_state;
    logic [1:0] dbg_reason;

    int errors = 0;
    int checks = 0;

    vending_machine_meal #(
        .DATA_W    (8),
        .ITEM_CODE (8'd1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .insert_cash      (insert_cash),
        .item_price       (item_price),
        .item_available   (item_available),
        .select_item      (select_item),
        .cancel           (cancel),
        .dispensed_item   (dispensed_item),
        .dispensed_change (dispensed_change),
        .error            (error),
        .dbg_state        (dbg_state),
        .dbg_reason       (dbg_reason)
    );

    // Clock: 10 ns period, rising edge active; bench drives and samples on falling edges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        select_item    = 1'b0;
        cancel         = 1'b0;
        insert_cash    = 8'd0;
        item_price     = 8'd0;
        item_available = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [7:0] item,
                                 input logic [7:0] change, input logic err);
        check({tag, ".item"},   32'(dispensed_item),   32'(item));
        check({tag, ".change"}, 32'(dispensed_change), 32'(change));
        check({tag, ".error"},  32'(error),            32'(err));
        check({tag, ".state"},  32'(dbg_state),        32'(DONE));
    endtask

    // One-cycle select pulse; inputs are scrambled right after the request edge
    // so a design that keeps reading live inputs gets caught. Checks the
    // intermediate states and that outputs stay 0 until edge N+2.
    task automatic run_select(input string tag, input logic [7:0] c, input logic [7:0] p,
                              input logic a, input state_t second);
        @(negedge clk);
        insert_cash    = c;
        item_price     = p;
        item_available = a;
        select_item    = 1'b1;
        @(negedge clk);
        select_item    = 1'b0;
        insert_cash    = ~c;
        item_price     = ~p;
        item_available = ~a;
        check({tag, ".eval"}, 32'(dbg_state), 32'(EVAL));
        @(negedge clk);
        check({tag, ".second"}, 32'(dbg_state), 32'(second));
        check({tag, ".early_change"}, 32'(dispensed_change), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_cancel(input string tag, input logic [7:0] c, input logic with_select);
        @(negedge clk);
        insert_cash = c;
        item_price  = 8'd1;
        item_available = 1'b1;
        cancel      = 1'b1;
        select_item = with_select;
        @(negedge clk);
        cancel      = 1'b0;
        select_item = 1'b0;
        insert_cash = ~c;
        check({tag, ".refund"}, 32'(dbg_state), 32'(REFUND));
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        select_item = 1'b0;
        cancel = 1'b0;
        insert_cash = 8'd0;
        item_price = 8'd0;
        item_available = 1'b0;

        // Reset state.
        do_reset();
        check("rst.item",   32'(dispensed_item),   32'd0);
        check("rst.change", 32'(dispensed_change), 32'd0);
        check("rst.error",  32'(error),            32'd0);
        check("rst.state",  32'(dbg_state),        32'(IDLE));

        // Idle with no request: nothing happens.
        insert_cash = 8'd77;
        repeat (3) @(negedge clk);
        check("idle.state",  32'(dbg_state),        32'(IDLE));
        check("idle.change", 32'(dispensed_change), 32'd0);

        // Normal vend: 50 - 30 = 20, held until reset.
        do_reset();
        run_select("vend", 8'd50, 8'd30, 1'b1, VEND);
        expect_result("vend", 8'd1, 8'd20, 1'b0);
        repeat (5) @(negedge clk);
        expect_result("vend_hold", 8'd1, 8'd20, 1'b0);

        // Insufficient funds: refund 20 with error.
        do_reset();
        run_select("nofunds", 8'd20, 8'd30, 1'b1, REFUND);
        expect_result("nofunds", 8'd0, 8'd20, 1'b1);
        check("nofunds.reason", 32'(dbg_reason), 32'(RSN_NO_FUNDS));

        // One short of price.
        do_reset();
        run_select("short1", 8'd29, 8'd30, 1'b1, REFUND);
        expect_result("short1", 8'd0, 8'd29, 1'b1);

        // Cancel: refund 40, no error.
        do_reset();
        run_cancel("cancel", 8'd40, 1'b0);
        expect_result("cancel", 8'd0, 8'd40, 1'b0);
        check("cancel.reason", 32'(dbg_reason), 32'(RSN_CANCEL));

        // Out of stock with enough cash: refund 50 with error.
        do_reset();
        run_select("nostock", 8'd50, 8'd30, 1'b0, REFUND);
        expect_result("nostock", 8'd0, 8'd50, 1'b1);
        check("nostock.reason", 32'(dbg_reason), 32'(RSN_NO_STOCK));

        // Exact payment: change 0.
        do_reset();
        run_select("exact", 8'd30, 8'd30, 1'b1, VEND);
        expect_result("exact", 8'd1, 8'd0, 1'b0);

        // Zero cash, zero price, available: vend with change 0.
        do_reset();
        run_select("free", 8'd0, 8'd0, 1'b1, VEND);
        expect_result("free", 8'd1, 8'd0, 1'b0);

        // Full-scale credit.
        do_reset();
        run_select("max", 8'd255, 8'd1, 1'b1, VEND);
        expect_result("max", 8'd1, 8'd254, 1'b0);

        // Select and cancel on the same edge: cancel wins.
        do_reset();
        run_cancel("both", 8'd40, 1'b1);
        expect_result("both", 8'd0, 8'd40, 1'b0);

        // Asynchronous reset while in EVAL aborts with no output.
        do_reset();
        @(negedge clk);
        insert_cash = 8'd50;
        item_price = 8'd30;
        item_available = 1'b1;
        select_item = 1'b1;
        @(negedge clk);
        select_item = 1'b0;
        check("abort.eval", 32'(dbg_state), 32'(EVAL));
        #2 reset = 1'b1;
        #1;
        check("abort.state",  32'(dbg_state),        32'(IDLE));
        check("abort.item",   32'(dispensed_item),   32'd0);
        check("abort.change", 32'(dispensed_change), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort.after_state",  32'(dbg_state),        32'(IDLE));
        check("abort.after_change", 32'(dispensed_change), 32'd0);
        check("abort.after_item",   32'(dispensed_item),   32'd0);

        // After DONE, new cash and requests are ignored.
        do_reset();
        run_select("sticky", 8'd50, 8'd30, 1'b1, VEND);
        expect_result("sticky", 8'd1, 8'd20, 1'b0);
        insert_cash = 8'd99;
        item_price = 8'd5;
        select_item = 1'b1;
        @(negedge clk);
        select_item = 1'b0;
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        repeat (3) @(negedge clk);
        expect_result("sticky_after", 8'd1, 8'd20, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
